register_tree_pq: RTL and testbench

Register-tree max-priority queue built from the existing three-input `comparator` (parent, left_child, right_child → new_parent/new_left_child/new_right_child). It is the consumer of that stage.
- Holds 2^TREE_DEPTH-1 heap-ordered registers.
- Accepts enqueue, dequeue and replace operations from a client.
- Restores heap order with level-alternating compare-swap passes.
- Presents the current maximum at the root output.

---
 rtl/register_tree_pkg.sv | 35 +++
 rtl/comparator.sv | 30 +++
 rtl/register_tree_pq.sv | 178 +++++++++++++++++
 tb/tb_register_tree_pq.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/register_tree_pkg.sv
// Shared types and tree-index helpers for the register-tree priority queue.
package register_tree_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SORT = 1'b1
  } state_t;

  function automatic int num_nodes(input int depth);
    return (32'sd1 <<< depth) - 32'sd1;
  endfunction

  function automatic int parent_idx(input int i);
    return (i - 32'sd1) / 32'sd2;
  endfunction

  function automatic int left_idx(input int i);
    return 32'sd2 * i + 32'sd1;
  endfunction

  function automatic int right_idx(input int i);
    return 32'sd2 * i + 32'sd2;
  endfunction

  // Root is level 0; level = floor(log2(i+1)).
  function automatic int level_of(input int i);
    int lvl;
    lvl = 32'sd0;
    for (int k = 0; k < 31; k++) begin
      lvl = (((i + 32'sd1) >>> (k + 1)) != 32'sd0) ? (k + 32'sd1) : lvl;
    end
    return lvl;
  endfunction

endpackage

// File: rtl/comparator.sv
// Three-way compare-swap stage: the largest of parent/children ends up in the parent,
// the displaced parent takes the winning child's slot, the other child is untouched.
module comparator #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] parent,
  input  logic [WIDTH-1:0] left_child,
  input  logic [WIDTH-1:0] right_child,
  output logic [WIDTH-1:0] new_parent,
  output logic [WIDTH-1:0] new_left_child,
  output logic [WIDTH-1:0] new_right_child
);

  // Pick the maximum; ties keep the parent in place and prefer the left child.
  always_comb begin
    new_parent      = parent;
    new_left_child  = left_child;
    new_right_child = right_child;
    if ((left_child > parent) && (left_child >= right_child)) begin
      new_parent     = left_child;
      new_left_child = parent;
    end else if (right_child > parent) begin
      new_parent      = right_child;
      new_right_child = parent;
    end else begin
      new_parent = parent;
    end
  end

endmodule

// File: rtl/register_tree_pq.sv
// Register-tree max-priority queue with enqueue/dequeue/replace and level-alternating sort.
// Optional drop counter output enabled by defining REGISTER_TREE_PQ_DROP_CNT_EN.
module register_tree_pq
  import register_tree_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int TREE_DEPTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_enqueue,
  input  logic                  i_dequeue,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  output logic [TREE_DEPTH-1:0] o_size,
  output logic                  o_full,
`ifdef REGISTER_TREE_PQ_DROP_CNT_EN
  output logic                  o_empty,
  output logic [15:0]           o_drop_count
`else
  output logic                  o_empty
`endif
);

  localparam int NUM_NODES    = num_nodes(TREE_DEPTH);
  localparam int NUM_INTERNAL = num_nodes(TREE_DEPTH - 1);
  localparam int KEY_W        = DATA_WIDTH + 1;
  localparam int SIZE_W       = TREE_DEPTH;
  localparam int CNT_W        = $clog2(TREE_DEPTH + 1);
  localparam logic [SIZE_W-1:0] SIZE_MAX = SIZE_W'(NUM_NODES);
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(TREE_DEPTH - 1);

  state_t              state_r, state_nxt_s;
  logic [KEY_W-1:0]    key_r        [NUM_NODES];
  logic [KEY_W-1:0]    key_nxt_s    [NUM_NODES];
  logic [KEY_W-1:0]    sort_s       [NUM_NODES];
  logic [KEY_W-1:0]    cmp_parent_s [NUM_NODES];
  logic [KEY_W-1:0]    cmp_left_s   [NUM_INTERNAL];
  logic [KEY_W-1:0]    cmp_right_s  [NUM_INTERNAL];
  logic [NUM_NODES-1:0] active_s;
  logic [SIZE_W-1:0]   size_r, size_nxt_s, last_s;
  logic [CNT_W-1:0]    cnt_r, cnt_nxt_s;
  logic                phase_r, phase_nxt_s;
  logic                full_s, empty_s, do_enq_s, do_deq_s;

  // Key = {valid, data}, so an empty slot always loses to an occupied one.
  for (genvar g = 0; g < NUM_NODES; g++) begin : g_node
    if (g < NUM_INTERNAL) begin : g_int
      localparam logic PARITY = 1'(level_of(g) % 2);
      comparator #(.WIDTH(KEY_W)) u_cmp (
        .parent          (key_r[g]),
        .left_child      (key_r[left_idx(g)]),
        .right_child     (key_r[right_idx(g)]),
        .new_parent      (cmp_parent_s[g]),
        .new_left_child  (cmp_left_s[g]),
        .new_right_child (cmp_right_s[g])
      );
      assign active_s[g] = (phase_r == PARITY);
    end else begin : g_leaf
      assign cmp_parent_s[g] = key_r[g];
      assign active_s[g]     = 1'b0;
    end
  end

  // Per-node result of one compare-swap pass: own comparator or the parent's.
  always_comb begin
    for (int j = 0; j < NUM_NODES; j++) begin
      if (active_s[j]) begin
        sort_s[j] = cmp_parent_s[j];
      end else if ((j > 0) && active_s[parent_idx(j)]) begin
        sort_s[j] = (j % 2 == 1) ? cmp_left_s[parent_idx(j)] : cmp_right_s[parent_idx(j)];
      end else begin
        sort_s[j] = key_r[j];
      end
    end
  end

  // Operation decode, node writes and state sequencing.
  always_comb begin
    state_nxt_s = state_r;
    size_nxt_s  = size_r;
    cnt_nxt_s   = cnt_r;
    phase_nxt_s = phase_r;
    key_nxt_s   = key_r;
    full_s      = (size_r == SIZE_MAX);
    empty_s     = (size_r == {SIZE_W{1'b0}});
    do_enq_s    = i_enqueue & ~full_s & (~i_dequeue | empty_s);
    do_deq_s    = i_dequeue & ~empty_s;
    last_s      = size_r - SIZE_W'(1);
    case (state_r)
      IDLE: begin
        if (do_enq_s) begin
          key_nxt_s[size_r] = {1'b1, i_data};
          size_nxt_s        = size_r + SIZE_W'(1);
        end else if (do_deq_s && i_enqueue) begin
          key_nxt_s[0] = {1'b1, i_data};
        end else if (do_deq_s) begin
          key_nxt_s[0]      = key_r[last_s];
          key_nxt_s[last_s] = {KEY_W{1'b0}};
          size_nxt_s        = last_s;
        end else begin
          size_nxt_s = size_r;
        end
        if (do_enq_s || do_deq_s) begin
          state_nxt_s = SORT;
          cnt_nxt_s   = CNT_LOAD;
          phase_nxt_s = 1'b0;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SORT: begin
        key_nxt_s   = sort_s;
        phase_nxt_s = ~phase_r;
        if (cnt_r == {CNT_W{1'b0}}) begin
          state_nxt_s = IDLE;
        end else begin
          cnt_nxt_s = cnt_r - CNT_W'(1);
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, occupancy and node storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      size_r  <= {SIZE_W{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
      phase_r <= 1'b0;
      for (int n = 0; n < NUM_NODES; n++) begin
        key_r[n] <= {KEY_W{1'b0}};
      end
    end else begin
      state_r <= state_nxt_s;
      size_r  <= size_nxt_s;
      cnt_r   <= cnt_nxt_s;
      phase_r <= phase_nxt_s;
      key_r   <= key_nxt_s;
    end
  end

`ifdef REGISTER_TREE_PQ_DROP_CNT_EN
  logic        drop_s;
  logic [15:0] drop_cnt_r;

  // A request seen in IDLE that neither enqueues nor dequeues is a drop.
  always_comb begin
    drop_s = (state_r == IDLE) & (i_enqueue | i_dequeue) & ~do_enq_s & ~do_deq_s;
  end

  // Saturating drop counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt_r <= 16'h0000;
    end else if (drop_s && (drop_cnt_r != 16'hFFFF)) begin
      drop_cnt_r <= drop_cnt_r + 16'h0001;
    end else begin
      drop_cnt_r <= drop_cnt_r;
    end
  end

  assign o_drop_count = drop_cnt_r;
`endif

  assign o_ready = (state_r == IDLE);
  assign o_data  = key_r[0][DATA_WIDTH-1:0];
  assign o_valid = key_r[0][DATA_WIDTH];
  assign o_size  = size_r;
  assign o_full  = (size_r == SIZE_MAX);
  assign o_empty = (size_r == {SIZE_W{1'b0}});

endmodule

// File: tb/tb_register_tree_pq.sv
// Randomized self-checking bench for register_tree_pq against a multiset reference model.
module tb_register_tree_pq;

  localparam int DW = 32;
  localparam int TD = 3;
  localparam int NN = 7;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_enqueue;
  logic          i_dequeue;
  logic [DW-1:0] i_data;
  logic          o_ready;
  logic [DW-1:0] o_data;
  logic          o_valid;
  logic [TD-1:0] o_size;
  logic          o_full;
  logic          o_empty;
`ifdef REGISTER_TREE_PQ_DROP_CNT_EN
  logic [15:0]   o_drop_count;
`endif

  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned model[$];
  int          drop_exp = 0;

  register_tree_pq #(.DATA_WIDTH(DW), .TREE_DEPTH(TD)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_enqueue (i_enqueue),
    .i_dequeue (i_dequeue),
    .i_data    (i_data),
    .o_ready   (o_ready),
    .o_data    (o_data),
    .o_valid   (o_valid),
    .o_size    (o_size),
    .o_full    (o_full),
`ifdef REGISTER_TREE_PQ_DROP_CNT_EN
    .o_empty   (o_empty),
    .o_drop_count (o_drop_count)
`else
    .o_empty   (o_empty)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input longint unsigned got, input longint unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int max_index();
    int idx = 0;
    for (int k = 1; k < model.size(); k++) begin
      if (model[k] > model[idx]) idx = k;
    end
    return idx;
  endfunction

  function automatic int unsigned model_max();
    return (model.size() == 0) ? 32'd0 : model[max_index()];
  endfunction

  task automatic check_state(input string tag);
    check_eq({tag, "_ready"}, o_ready, 1);
    check_eq({tag, "_data"},  o_data,  model_max());
    check_eq({tag, "_valid"}, o_valid, (model.size() > 0) ? 1 : 0);
    check_eq({tag, "_size"},  o_size,  model.size());
    check_eq({tag, "_full"},  o_full,  (model.size() == NN) ? 1 : 0);
    check_eq({tag, "_empty"}, o_empty, (model.size() == 0) ? 1 : 0);
`ifdef REGISTER_TREE_PQ_DROP_CNT_EN
    check_eq({tag, "_drops"}, o_drop_count, drop_exp);
`endif
  endtask

  // Issue one request for a single cycle at a negedge, then wait out the sort.
  task automatic do_op(input bit enq, input bit deq, input logic [DW-1:0] d, input string tag);
    int busy;
    bit do_enq, do_deq;
    do_enq = enq && (model.size() < NN) && (!deq || model.size() == 0);
    do_deq = deq && (model.size() > 0);
    if (do_deq) check_eq({tag, "_deq_value"}, o_data, model_max());
    i_enqueue = enq;
    i_dequeue = deq;
    i_data    = d;
    @(negedge clk);
    i_enqueue = 1'b0;
    i_dequeue = 1'b0;
    if (do_enq) begin
      model.push_back(d);
    end else if (do_deq) begin
      model.delete(max_index());
      if (enq) model.push_back(d);
    end else if (enq || deq) begin
      if (drop_exp < 65535) drop_exp++;
    end
    busy = 0;
    while (o_ready !== 1'b1 && busy < 20) begin
      busy++;
      @(negedge clk);
    end
    check_eq({tag, "_busy"}, busy, (do_enq || do_deq) ? TD : 0);
    check_state(tag);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model.delete();
    drop_exp = 0;
  endtask

  initial begin
    rst       = 1'b1;
    i_enqueue = 1'b0;
    i_dequeue = 1'b0;
    i_data    = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_state("reset");

    do_op(1'b1, 1'b0, 32'h10, "enq10");
    do_op(1'b1, 1'b0, 32'h30, "enq30");
    do_op(1'b1, 1'b0, 32'h20, "enq20");
    check_eq("three_max", o_data, 32'h30);

    pulse_reset();
    for (int v = 1; v <= NN; v++) do_op(1'b1, 1'b0, DW'(v), "fill");
    do_op(1'b1, 1'b0, 32'h99, "enq_full");
    check_eq("full_flag", o_full, 1);
    for (int v = NN; v >= 1; v--) begin
      check_eq("deq_seq", o_data, v);
      do_op(1'b0, 1'b1, '0, "drain");
    end
    check_eq("drained_valid", o_valid, 0);
    do_op(1'b0, 1'b1, '0, "deq_empty");
    do_op(1'b1, 1'b1, 32'h77, "repl_empty");
    check_eq("repl_empty_data", o_data, 32'h77);

    pulse_reset();
    do_op(1'b1, 1'b0, 32'h5, "q5");
    do_op(1'b1, 1'b0, 32'h8, "q8");
    do_op(1'b1, 1'b0, 32'h2, "q2");
    check_eq("replace_ret", o_data, 32'h8);
    do_op(1'b1, 1'b1, 32'h1, "replace");
    check_eq("replace_root", o_data, 32'h5);

    // Reset arriving in the middle of a sort.
    @(negedge clk);
    i_enqueue = 1'b1;
    i_data    = 32'h40;
    @(negedge clk);
    i_enqueue = 1'b0;
    check_eq("mid_sort_busy", o_ready, 0);
    rst = 1'b1;
    #1;
    model.delete();
    drop_exp = 0;
    check_state("mid_sort_rst");
    @(negedge clk);
    rst = 1'b0;
    do_op(1'b1, 1'b0, 32'h11, "post_rst");
    check_eq("post_rst_data", o_data, 32'h11);

    for (int it = 0; it < 300; it++) begin
      int unsigned kind;
      logic [DW-1:0] d;
      kind = $urandom_range(0, 4);
      d = ($urandom_range(0, 1) == 0) ? DW'($urandom) : DW'($urandom_range(0, 7));
      case (kind)
        0, 1: do_op(1'b1, 1'b0, d, "rnd_enq");
        2:    do_op(1'b0, 1'b1, d, "rnd_deq");
        3:    do_op(1'b1, 1'b1, d, "rnd_repl");
        default: begin
          @(negedge clk);
          check_state("rnd_idle");
        end
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
